// File: rtl/sprite_loader.sv
// Streams packed 4-bit palette bytes into the sprite-sheet frame RAM write port in raster order.
// Optional `SPRITE_LOADER_CHECKSUM_EN adds a trailing mod-256 checksum byte check.
module sprite_loader #(
    parameter int unsigned SS_WIDTH  = 200,
    parameter int unsigned SS_HEIGHT = 200,
    parameter int unsigned ADDR_W    = 16
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic [ADDR_W-1:0] write_address,
    output logic [3:0]        data_In,
    output logic              we,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int unsigned       DEPTH     = SS_WIDTH * SS_HEIGHT;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ACCEPT = 3'd1,
        S_WR_LO  = 3'd2,
        S_WR_HI  = 3'd3,
        S_DONE   = 3'd4
`ifdef SPRITE_LOADER_CHECKSUM_EN
        , S_CHECK = 3'd5
`endif
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] wa_q, wa_d;
    logic [3:0]        hi_q, hi_d;
    logic [3:0]        data_q, data_d;
    logic              in_ready_q, in_ready_d;
    logic              we_q, we_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              hs_c;
    logic              load_c;
`ifdef SPRITE_LOADER_CHECKSUM_EN
    logic [7:0]        sum_q, sum_d;
    logic [7:0]        total_c;
    logic              error_q, error_d;
`endif

    // Next-state and next-output decode; outputs are registered from these values.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wa_d       = wa_q;
        hi_d       = hi_q;
        data_d     = data_q;
        in_ready_d = 1'b0;
        we_d       = 1'b0;
        busy_d     = busy_q;
        done_d     = done_q;
        hs_c       = in_valid && in_ready_q;
        load_c     = 1'b0;
`ifdef SPRITE_LOADER_CHECKSUM_EN
        sum_d      = sum_q;
        error_d    = error_q;
        total_c    = sum_q + in_data;
`endif

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start && !abort) begin
                    state_d    = S_ACCEPT;
                    addr_d     = '0;
                    done_d     = 1'b0;
                    busy_d     = 1'b1;
                    in_ready_d = 1'b1;
`ifdef SPRITE_LOADER_CHECKSUM_EN
                    sum_d      = 8'd0;
                    error_d    = 1'b0;
`endif
                end
            end
            S_ACCEPT: begin
                if (hs_c) begin
                    load_c = 1'b1;
                end else begin
                    in_ready_d = 1'b1;
                end
            end
            S_WR_LO: begin
                state_d    = S_WR_HI;
                we_d       = 1'b1;
                wa_d       = addr_q;
                data_d     = hi_q;
                addr_d     = addr_q + ADDR_W'(1);
                in_ready_d = (addr_q != LAST_ADDR);
            end
            S_WR_HI: begin
                if (wa_q == LAST_ADDR) begin
`ifdef SPRITE_LOADER_CHECKSUM_EN
                    state_d    = S_CHECK;
                    in_ready_d = 1'b1;
`else
                    state_d    = S_DONE;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
`endif
                end else if (hs_c) begin
                    load_c = 1'b1;
                end else begin
                    state_d    = S_ACCEPT;
                    in_ready_d = 1'b1;
                end
            end
`ifdef SPRITE_LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (hs_c) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    error_d = (total_c != 8'd0);
                end else begin
                    in_ready_d = 1'b1;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase

        // Accepted byte: low nibble is written next cycle, high nibble is parked.
        if (load_c) begin
            state_d = S_WR_LO;
            we_d    = 1'b1;
            wa_d    = addr_q;
            data_d  = in_data[3:0];
            hi_d    = in_data[7:4];
            addr_d  = addr_q + ADDR_W'(1);
`ifdef SPRITE_LOADER_CHECKSUM_EN
            sum_d   = total_c;
`endif
        end

        // Abort outranks everything; any pending high-nibble write is dropped.
        if (abort && busy_q) begin
            state_d    = S_IDLE;
            we_d       = 1'b0;
            in_ready_d = 1'b0;
            busy_d     = 1'b0;
            done_d     = 1'b0;
            wa_d       = wa_q;
            data_d     = data_q;
`ifdef SPRITE_LOADER_CHECKSUM_EN
            error_d    = 1'b0;
`endif
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            wa_q       <= '0;
            hi_q       <= 4'd0;
            data_q     <= 4'd0;
            in_ready_q <= 1'b0;
            we_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef SPRITE_LOADER_CHECKSUM_EN
            sum_q      <= 8'd0;
            error_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wa_q       <= wa_d;
            hi_q       <= hi_d;
            data_q     <= data_d;
            in_ready_q <= in_ready_d;
            we_q       <= we_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef SPRITE_LOADER_CHECKSUM_EN
            sum_q      <= sum_d;
            error_q    <= error_d;
`endif
        end
    end

    assign in_ready      = in_ready_q;
    assign write_address = wa_q;
    assign data_In       = data_q;
    assign we            = we_q;
    assign busy          = busy_q;
    assign done          = done_q;
`ifdef SPRITE_LOADER_CHECKSUM_EN
    assign error         = error_q;
`else
    assign error         = 1'b0;
`endif

endmodule

// File: tb/tb_sprite_loader.sv
// Scoreboard bench for sprite_loader: the driver queues expected RAM writes per accepted byte,
// a negedge monitor pops and compares every write the DUT issues.
module tb_sprite_loader;

    localparam int DEPTH = 40000;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        start;
    logic        abort;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic [15:0] write_address;
    logic [3:0]  data_In;
    logic        we;
    logic        busy;
    logic        done;
    logic        error;

    sprite_loader #(.SS_WIDTH(200), .SS_HEIGHT(200), .ADDR_W(16)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .start(start), .abort(abort),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .write_address(write_address), .data_In(data_In), .we(we),
        .busy(busy), .done(done), .error(error)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [15:0] a;
        logic [3:0]  d;
    } wr_t;

    wr_t         exp_q[$];
    int          wr_cyc_q[$];
    wr_t         mon_e;
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          last_wr_cyc = 0;
    logic [15:0] last_wa = '0;
    logic [3:0]  last_d = '0;
    int          model_addr = 0;
    logic [7:0]  model_sum = 8'd0;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every RAM write must be the next one the image model predicts.
    always @(negedge Clk) begin
        if (Reset_n && we) begin
            wr_cyc_q.push_back(cyc);
            last_wr_cyc = cyc;
            last_wa     = write_address;
            last_d      = data_In;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr %0d data %0h, none expected", write_address, data_In);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", 32'(write_address), 32'(mon_e.a));
                check("wr_data", 32'(data_In), 32'(mon_e.d));
            end
            if (write_address == 16'(DEPTH - 1))
                check("in_ready_last_wr", 32'(in_ready), 32'd0);
            else
                check("in_ready_during_wr", 32'(in_ready), 32'(write_address[0]));
            check("busy_during_wr", 32'(busy), 32'd1);
        end
    end

    task automatic push_byte(input logic [7:0] b);
        exp_q.push_back('{a: 16'(model_addr), d: b[3:0]});
        exp_q.push_back('{a: 16'(model_addr + 1), d: b[7:4]});
        model_addr += 2;
        model_sum  += b;
    endtask

    // mode 0: valid held high, 1: random valid, 2: valid toggles every 3 cycles
    task automatic send(input int n, input int mode, input bit fixed_en, input logic [7:0] fixed_val);
        int         sent  = 0;
        int         guard = 0;
        logic [7:0] b;
        bit         v;
        b = fixed_en ? fixed_val : 8'($urandom);
        while (sent < n && guard < 8 * n + 100) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = ($urandom_range(0, 2) != 0);
                default: v = ((guard / 3) % 2) == 0;
            endcase
            in_valid = v;
            in_data  = b;
            if (v && in_ready) begin
                push_byte(b);
                sent++;
                b = fixed_en ? fixed_val : 8'($urandom);
            end
            @(negedge Clk);
            guard++;
        end
        in_valid = 1'b0;
        check("bytes_accepted", 32'(sent), 32'(n));
    endtask

    task automatic offer(input logic [7:0] b);
        int g = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && g < 20) begin
            @(negedge Clk);
            g++;
        end
        check("offer_ready", 32'(in_ready), 32'd1);
        if (in_ready) push_byte(b);
        @(negedge Clk);
    endtask

    task automatic start_load();
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        model_addr = 0;
        model_sum  = 8'd0;
        check("busy_after_start", 32'(busy), 32'd1);
        check("done_cleared_by_start", 32'(done), 32'd0);
        check("error_cleared_by_start", 32'(error), 32'd0);
    endtask

    task automatic abort_load();
        in_valid = 1'b0;
        abort    = 1'b1;
        @(negedge Clk);
        abort = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_we", 32'(we), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_error", 32'(error), 32'd0);
        exp_q.delete();
    endtask

    task automatic wait_done();
        int g = 0;
        while (!done && g < 10) begin
            @(negedge Clk);
            g++;
        end
        check("done_reached", 32'(done), 32'd1);
        check("busy_at_done", 32'(busy), 32'd0);
    endtask

`ifdef SPRITE_LOADER_CHECKSUM_EN
    task automatic full_checked_load(input logic [7:0] ck);
        int g = 0;
        start_load();
        send(DEPTH / 2, 0, 1'b1, 8'h01);
        while (!in_ready && g < 10) begin
            @(negedge Clk);
            g++;
        end
        check("check_ready", 32'(in_ready), 32'd1);
        check("check_no_writes_left", 32'(exp_q.size()), 32'd0);
        in_valid = 1'b1;
        in_data  = ck;
        @(negedge Clk);
        in_valid = 1'b0;
        wait_done();
        check("checksum_error", 32'(error), 32'((8'(model_sum + ck)) != 8'd0));
        repeat (3) @(negedge Clk);
        check("done_held", 32'(done), 32'd1);
        check("error_held", 32'(error), 32'((8'(model_sum + ck)) != 8'd0));
    endtask
`endif

    initial begin
        Reset_n  = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'd0;
        repeat (3) @(negedge Clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_we", 32'(we), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_addr", 32'(write_address), 32'd0);
        Reset_n = 1'b1;
        @(negedge Clk);

        // Back-to-back: 0x21, 0x43 -> four writes on consecutive cycles
        start_load();
        check("accept_ready", 32'(in_ready), 32'd1);
        wr_cyc_q.delete();
        offer(8'h21);
        offer(8'h43);
        in_valid = 1'b0;
        repeat (3) @(negedge Clk);
        check("b2b_write_count", 32'(wr_cyc_q.size()), 32'd4);
        if (wr_cyc_q.size() == 4)
            check("b2b_consecutive", 32'(wr_cyc_q[3] - wr_cyc_q[0]), 32'd3);
        check("b2b_all_written", 32'(exp_q.size()), 32'd0);
        abort_load();

        // Bubbled and random-valid sources with random data
        start_load();
        send(30, 2, 1'b0, 8'h00);
        send(40, 1, 1'b0, 8'h00);
        repeat (3) @(negedge Clk);
        check("bubble_all_written", 32'(exp_q.size()), 32'd0);
        abort_load();

        // Abort in WR_LO of byte 5; a start mid-load must be ignored
        start_load();
        send(2, 0, 1'b0, 8'h00);
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        send(2, 1, 1'b0, 8'h00);
        begin
            int g = 0;
            in_valid = 1'b1;
            in_data  = 8'h9C;
            while (!in_ready && g < 10) begin
                @(negedge Clk);
                g++;
            end
            exp_q.push_back('{a: 16'(model_addr), d: 4'hC});
            @(negedge Clk);
            check("abort_lo_we", 32'(we), 32'd1);
            check("abort_lo_addr", 32'(write_address), 32'd8);
        end
        in_valid = 1'b0;
        abort    = 1'b1;
        @(negedge Clk);
        abort = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_we", 32'(we), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_lo_written", 32'(exp_q.size()), 32'd0);
        repeat (4) @(negedge Clk);

        // start and abort together while idle: stay idle
        start = 1'b1;
        abort = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_idle", 32'(busy), 32'd0);
        check("start_abort_ready", 32'(in_ready), 32'd0);

        // Reset mid-load after 10 bytes
        start_load();
        send(10, 0, 1'b0, 8'h00);
        Reset_n = 1'b0;
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        check("midrst_we", 32'(we), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_error", 32'(error), 32'd0);
        check("midrst_addr", 32'(write_address), 32'd0);
        check("midrst_data", 32'(data_In), 32'd0);
        exp_q.delete();
        @(negedge Clk);
        Reset_n  = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h77;
        repeat (5) begin
            @(negedge Clk);
            check("post_rst_not_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;

`ifdef SPRITE_LOADER_CHECKSUM_EN
        full_checked_load(8'hE0);
        full_checked_load(8'hE1);
        start_load();
        abort_load();
`else
        // Full image of 0xA5 with valid held high
        start_load();
        send(DEPTH / 2, 0, 1'b1, 8'hA5);
        wait_done();
        check("full_done_latency", 32'(cyc - last_wr_cyc), 32'd1);
        check("full_last_addr", 32'(last_wa), 32'(DEPTH - 1));
        check("full_last_data", 32'(last_d), 32'hA);
        check("full_error", 32'(error), 32'd0);
        check("full_all_written", 32'(exp_q.size()), 32'd0);
        repeat (3) @(negedge Clk);
        check("done_held", 32'(done), 32'd1);
        start_load();
        abort_load();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
